rtc_seg_display: RTL

RTC_SEG_DISPLAY -- requirements
Module: rtc_seg_display

---
 rtl/rtc_seg_if.sv | 19 +
 rtl/rtc_seg_display.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rtc_seg_if.sv
// RTC read bus in, multiplexed 6-digit 7-segment drive out.
interface rtc_seg_if;
  logic       time_valid;
  logic [7:0] read_second;
  logic [7:0] read_minute;
  logic [7:0] read_hour;
  logic [5:0] seg_sel;
  logic [7:0] seg_data;

  modport master (
    output time_valid, read_second, read_minute, read_hour,
    input  seg_sel, seg_data
  );

  modport slave (
    input  time_valid, read_second, read_minute, read_hour,
    output seg_sel, seg_data
  );
endinterface

// File: rtl/rtc_seg_display.sv
// HH:MM:SS scanner for six common-anode digits; blink dp tracks seconds changes.
// Optional RTC_SEG_HALT_BLINK_EN blanks the display on alternate quarter seconds while CH is set.
module rtc_seg_display #(
  parameter int CLK_FREQ  = 50000000,
  parameter int SCAN_FREQ = 1000
) (
  input logic      clk,
  input logic      rst_n,
  rtc_seg_if.slave bus
);
  localparam int SCAN_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CW       = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic          on_q, on_d;
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    hr_q, hr_d;
  logic          ph_q, ph_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    dat_q, dat_d;
  logic          tc;
  logic [3:0]    nib;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  endfunction

  // on_q keeps the display dark until the first terminal count, which then shows digit 0.
  always_comb begin
    tc    = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d = tc ? '0 : cnt_q + CW'(1);
    on_d  = on_q | tc;
    dig_d = dig_q;
    if (tc && on_q) dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    ph_d  = ph_q;
    if (bus.time_valid) begin
      sec_d = bus.read_second[6:0];
      min_d = bus.read_minute[6:0];
      hr_d  = bus.read_hour[5:0];
      ph_d  = ph_q ^ (bus.read_second[6:0] != sec_q);
    end
  end

`ifdef RTC_SEG_HALT_BLINK_EN
  localparam int HALF = CLK_FREQ / 4;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic          ch_q;
  logic [HW-1:0] hb_cnt_q;
  logic          hb_ph_q;
  logic          unused_bits;
  assign unused_bits = ^{bus.read_minute[7], bus.read_hour[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= 1'b0;
      hb_cnt_q <= HW'(HALF - 1);
      hb_ph_q  <= 1'b0;
    end else begin
      if (bus.time_valid) ch_q <= bus.read_second[7];
      if (hb_cnt_q == '0) begin
        hb_cnt_q <= HW'(HALF - 1);
        hb_ph_q  <= ~hb_ph_q;
      end else begin
        hb_cnt_q <= hb_cnt_q - HW'(1);
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bus.read_second[7], bus.read_minute[7], bus.read_hour[7:6]};
`endif

  always_comb begin
    case (dig_q)
      3'd0:    nib = sec_q[3:0];
      3'd1:    nib = {1'b0, sec_q[6:4]};
      3'd2:    nib = min_q[3:0];
      3'd3:    nib = {1'b0, min_q[6:4]};
      3'd4:    nib = hr_q[3:0];
      3'd5:    nib = {2'b00, hr_q[5:4]};
      default: nib = 4'd0;
    endcase
    sel_d = 6'h3F;
    dat_d = 8'hFF;
    if (on_q) begin
      sel_d = ~(6'd1 << dig_q);
      dat_d = {~(ph_q && (dig_q == 3'd2 || dig_q == 3'd4)), glyph(nib)};
    end
`ifdef RTC_SEG_HALT_BLINK_EN
    if (ch_q && hb_ph_q) sel_d = 6'h3F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= 3'd0;
      on_q  <= 1'b0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
      ph_q  <= 1'b0;
      sel_q <= 6'h3F;
      dat_q <= 8'hFF;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      on_q  <= on_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
      ph_q  <= ph_d;
      sel_q <= sel_d;
      dat_q <= dat_d;
    end
  end

  assign bus.seg_sel  = sel_q;
  assign bus.seg_data = dat_q;
endmodule
